// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU definitions: control codes used by both the issue stage and the ALU,
// plus the issue-stage output record.
package alu_issue_stage_pkg;

    localparam int ALU_XLEN = 32;
    localparam int CTRL_W   = 6;
    localparam int RIDX_W   = 5;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 6'b000000;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 6'b000001;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 6'b000010;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 6'b000011;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 6'b000100;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 6'b000101;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 6'b000110;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 6'b000111;
    localparam logic [CTRL_W-1:0] ALU_OR   = 6'b001000;
    localparam logic [CTRL_W-1:0] ALU_AND  = 6'b001001;
    localparam logic [CTRL_W-1:0] ALU_BEQ  = 6'b001010;
    localparam logic [CTRL_W-1:0] ALU_BNE  = 6'b001011;
    localparam logic [CTRL_W-1:0] ALU_BLT  = 6'b001100;
    localparam logic [CTRL_W-1:0] ALU_BGE  = 6'b001101;
    localparam logic [CTRL_W-1:0] ALU_BLTU = 6'b001110;
    localparam logic [CTRL_W-1:0] ALU_BGEU = 6'b001111;
    localparam logic [CTRL_W-1:0] ALU_JAL  = 6'b011111;
    localparam logic [CTRL_W-1:0] ALU_JALR = 6'b111111;

    typedef struct packed {
        logic [CTRL_W-1:0]   ctrl;
        logic [ALU_XLEN-1:0] op_a;
        logic [ALU_XLEN-1:0] op_b;
        logic [ALU_XLEN-1:0] rs2;
        logic [ALU_XLEN-1:0] pc;
        logic [RIDX_W-1:0]   rd;
    } issue_pkt_t;

    function automatic logic is_branch(input logic [CTRL_W-1:0] c);
        return (c >= ALU_BEQ) && (c <= ALU_BGEU);
    endfunction

    function automatic logic is_jump(input logic [CTRL_W-1:0] c);
        return (c == ALU_JAL) || (c == ALU_JALR);
    endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Source-value resolution for one register operand. Forwarding from the downstream
// result is compiled in only with FORWARDING_EN; otherwise fwd_* are ignored.
module operand_fwd_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      i_idx,
    input  logic [XLEN-1:0] i_rf_data,
    input  logic            i_fwd_we,
    input  logic [4:0]      i_fwd_idx,
    input  logic [XLEN-1:0] i_fwd_data,
    output logic [XLEN-1:0] o_data
);

`ifdef FORWARDING_EN
    always_comb begin
        o_data = i_rf_data;
        if (i_idx == 5'd0)
            o_data = '0;
        else if (i_fwd_we && (i_fwd_idx == i_idx))
            o_data = i_fwd_data;
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{i_fwd_we, i_fwd_idx, i_fwd_data};

    always_comb begin
        o_data = i_rf_data;
        if (i_idx == 5'd0)
            o_data = '0;
    end
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry registered issue stage between decode and the ALU: resolves sources,
// selects operands, and handshakes both sides. Optional forwarding: FORWARDING_EN.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32  // only 32 is legal
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_alu_ctrl,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rs1_idx,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [4:0]      in_rs2_idx,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic            in_use_pc,
    input  logic [4:0]      in_rd_idx,
    input  logic            fwd_we,
    input  logic [4:0]      fwd_idx,
    input  logic [XLEN-1:0] fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      ALU_Control,
    output logic [XLEN-1:0] operand_A,
    output logic [XLEN-1:0] operand_B,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd_idx
);

    logic            r_valid;
    issue_pkt_t      r_pkt;
    issue_pkt_t      w_pkt;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic            w_in_ready;
    logic            w_capture;

    operand_fwd_mux #(.XLEN(XLEN)) u_rs1_mux (
        .i_idx      (in_rs1_idx),
        .i_rf_data  (in_rs1_data),
        .i_fwd_we   (fwd_we),
        .i_fwd_idx  (fwd_idx),
        .i_fwd_data (fwd_data),
        .o_data     (w_rs1)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_rs2_mux (
        .i_idx      (in_rs2_idx),
        .i_rf_data  (in_rs2_data),
        .i_fwd_we   (fwd_we),
        .i_fwd_idx  (fwd_idx),
        .i_fwd_data (fwd_data),
        .o_data     (w_rs2)
    );

    assign w_in_ready = rst_n & ~flush & (~r_valid | out_ready);
    assign w_capture  = in_valid & w_in_ready;

    // Jumps carry PC and the link increment; branches always compare rs1 against rs2.
    always_comb begin
        w_pkt      = '0;
        w_pkt.ctrl = in_alu_ctrl;
        w_pkt.rs2  = w_rs2;
        w_pkt.pc   = in_pc;
        w_pkt.rd   = in_rd_idx;
        w_pkt.op_a = (is_jump(in_alu_ctrl) || in_use_pc) ? in_pc : w_rs1;
        if (is_jump(in_alu_ctrl))
            w_pkt.op_b = 32'd4;
        else if (is_branch(in_alu_ctrl))
            w_pkt.op_b = w_rs2;
        else if (in_use_imm)
            w_pkt.op_b = in_imm;
        else
            w_pkt.op_b = w_rs2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_pkt   <= w_pkt;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_valid;
    assign ALU_Control  = r_pkt.ctrl;
    assign operand_A    = r_pkt.op_a;
    assign operand_B    = r_pkt.op_b;
    assign out_rs2_data = r_pkt.rs2;
    assign out_pc       = r_pkt.pc;
    assign out_rd_idx   = r_pkt.rd;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage
Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; the only legal value is 32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port flush, input, 1, discards the held instruction and any incoming one.
REQ-005 SHALL have port in_valid, input, 1, decode presents an instruction.
REQ-006 SHALL have port in_ready, output, 1, stage accepts this cycle.
REQ-007 SHALL have port in_alu_ctrl, input, 6, ALU control code from decode.
REQ-008 SHALL have port in_pc, input, XLEN, instruction PC.
REQ-009 SHALL have port in_rs1_idx, input, 5, source register 1 index.
REQ-010 SHALL have port in_rs1_data, input, XLEN, register-file read data for rs1.
REQ-011 SHALL have port in_rs2_idx, input, 5, source register 2 index.
REQ-012 SHALL have port in_rs2_data, input, XLEN, register-file read data for rs2.
REQ-013 SHALL have port in_imm, input, XLEN, sign-extended immediate.
REQ-014 SHALL have port in_use_imm, input, 1, operand B takes the immediate.
REQ-015 SHALL have port in_use_pc, input, 1, operand A takes the PC.
REQ-016 SHALL have port in_rd_idx, input, 5, destination register; 0 means no writeback.
REQ-017 SHALL have port fwd_we, input, 1, downstream result is valid for forwarding.
REQ-018 SHALL have port fwd_idx, input, 5, downstream destination index.
REQ-019 SHALL have port fwd_data, input, XLEN, downstream result value.
REQ-020 SHALL have port out_valid, output, 1, registered instruction valid to ALU.
REQ-021 SHALL have port out_ready, input, 1, ALU stage consumes this cycle.
REQ-022 SHALL have port ALU_Control, output, 6, registered control code to ALU.
REQ-023 SHALL have port operand_A, output, XLEN, registered ALU operand A.
REQ-024 SHALL have port operand_B, output, XLEN, registered ALU operand B.
REQ-025 SHALL have port out_rs2_data, output, XLEN, resolved rs2 value (store data).
REQ-026 SHALL have port out_pc, output, XLEN, registered PC.
REQ-027 SHALL have port out_rd_idx, output, 5, registered destination index.
Function
REQ-028 SHALL drive in_ready = rst_n & !flush & (!out_valid | out_ready), combinationally.
REQ-029 SHALL capture on in_valid & in_ready at a rising edge, setting out_valid=1 next cycle (latency 1).
REQ-030 SHALL clear out_valid when out_valid & out_ready and no capture; capture plus drain in one edge keeps out_valid=1 with new contents.
REQ-031 SHALL hold every output stable while out_valid & !out_ready.
REQ-032 SHALL resolve each source value at capture: 0 if idx==0; else fwd_data if fwd_we & fwd_idx==idx; else in_rsN_data.
REQ-033 SHALL set operand_A = in_pc for JAL(011111)/JALR(111111) or in_use_pc, else resolved rs1.
REQ-034 SHALL set operand_B = 4 for JAL/JALR; resolved rs2 for branch codes 001010-001111 regardless of in_use_imm; else in_imm if in_use_imm, else resolved rs2.
REQ-035 SHALL pass in_alu_ctrl, including undefined codes, to ALU_Control unchanged; out_rs2_data always equals resolved rs2.
REQ-036 SHALL on flush clear out_valid at the next edge and capture nothing; flush takes priority over capture and hold.
Reset
REQ-037 SHALL, at a rising edge with rst_n=0, set out_valid=0, ALU_Control=000000, and operand_A, operand_B, out_rs2_data, out_pc, out_rd_idx=0; reset overrides flush and capture.
Configuration
REQ-038 SHALL, with FORWARDING_EN defined, implement REQ-032 forwarding; without it, ignore fwd_* (rs value = 0 for idx 0, else in_rsN_data), and upstream inserts bubbles.
Structure
REQ-039 SHALL take ALU control codes (ADD..AND, BEQ..BGEU, JAL, JALR) from the shared ALU definitions include also used by the ALU.
REQ-040 SHALL implement source resolution as sub-module operand_fwd_mux, instantiated once per source.
Verification
REQ-041 SHALL check ADD: rs1_idx=3 data=15, imm=10, use_imm=1, out_ready=1 -> next cycle out_valid=1, ALU_Control=000000, A=15, B=10.
REQ-042 SHALL check forwarding: rs1_idx=5 data=1, fwd_we=1 fwd_idx=5 fwd_data=A5A5A5A5 -> A=A5A5A5A5; rs1_idx=0 with fwd_idx=0 -> A=0.
REQ-043 SHALL check backpressure: out_ready=0 for 2 cycles -> in_ready=0, outputs stable; release -> first drains, second captured same edge, out_valid stays 1.
REQ-044 SHALL check JAL pc=100 -> A=100, B=4; BEQ rs2=15 with use_imm=1 imm=7 -> B=15.
REQ-045 SHALL check flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0; rst_n=0 for one edge mid-stream -> out_valid=0, ALU_Control=000000.
